// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. Drives the program counter to a combinational
// instruction memory and captures the returned word into an instruction
// register (IR) for decode. Supports decode back-pressure, jump/branch
// redirect with flush, a HALT state entered on a configurable opcode, a
// per-instruction PC tag and a saturating count of valid captures.
//
// Ports:
//   clk_i               in   clock, rising edge
//   rst_i               in   asynchronous reset, active low
//   pc_o                out  address to instruction memory
//   instruction_i       in   memory word for the current pc_o (same cycle)
//   stall_i             in   decode cannot accept; hold IR and PC
//   jmp_en_i            in   redirect request (overrides stall)
//   jmp_addr_i          in   redirect target
//   resume_i            in   leave HALT and continue at PC+1
//   fetch_instruction_o out  IR contents
//   fetch_valid_o       out  IR holds a real instruction (not a bubble)
//   fetch_pc_o          out  address the IR word was fetched from
//   halted_o            out  unit is in HALT
//   fetch_count_o       out  number of valid IR captures (saturating)
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int                    A_BITS   = 10,
  parameter int                    I_BITS   = 16,
  parameter int                    OPC_BITS = 4,
  parameter logic [OPC_BITS-1:0]   HALT_OPC = 4'hF,
  parameter logic [I_BITS-1:0]     NOP_WORD = '0,
  parameter logic [A_BITS-1:0]     RESET_PC = '0,
  parameter int                    CNT_BITS = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  output logic [A_BITS-1:0]   pc_o,
  input  logic [I_BITS-1:0]   instruction_i,
  input  logic                stall_i,
  input  logic                jmp_en_i,
  input  logic [A_BITS-1:0]   jmp_addr_i,
  input  logic                resume_i,
  output logic [I_BITS-1:0]   fetch_instruction_o,
  output logic                fetch_valid_o,
  output logic [A_BITS-1:0]   fetch_pc_o,
  output logic                halted_o,
  output logic [CNT_BITS-1:0] fetch_count_o
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [A_BITS-1:0]   pc_q, pc_d;
  logic [I_BITS-1:0]   ir_q, ir_d;
  logic                valid_q, valid_d;
  logic [A_BITS-1:0]   fetch_pc_q, fetch_pc_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  logic                is_halt_opc;
  logic [A_BITS-1:0]   pc_inc;
  logic [CNT_BITS-1:0] cnt_sat_inc;

  assign is_halt_opc = (instruction_i[I_BITS-1 -: OPC_BITS] == HALT_OPC);
  // Modulo 2^A_BITS: all-ones wraps to zero silently.
  assign pc_inc      = pc_q + A_BITS'(1);
  assign cnt_sat_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_BITS'(1);

  // ---------------------------------------------------------------------------
  // State / datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      ir_q       <= NOP_WORD;
      valid_q    <= 1'b0;
      fetch_pc_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      valid_q    <= valid_d;
      fetch_pc_q <= fetch_pc_d;
      cnt_q      <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Priority: redirect > stall > halt detect / resume.
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output is given a default first so no path
  // through the block leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    if (jmp_en_i) begin
      state_d = ST_RUN;
    end else if (!stall_i) begin
      unique case (state_q)
        ST_RUN:  if (is_halt_opc) state_d = ST_HALT;
        ST_HALT: if (resume_i)    state_d = ST_RUN;
        default: state_d = ST_RUN;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // PC / IR / tag / counter updates
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d       = pc_q;
    ir_d       = ir_q;
    valid_d    = valid_q;
    fetch_pc_d = fetch_pc_q;
    cnt_d      = cnt_q;

    if (jmp_en_i) begin
      // Flush: the word at the old PC is discarded, leaving one bubble.
      pc_d    = jmp_addr_i;
      ir_d    = NOP_WORD;
      valid_d = 1'b0;
    end else if (!stall_i) begin
      unique case (state_q)
        ST_RUN: begin
          ir_d       = instruction_i;
          valid_d    = 1'b1;
          fetch_pc_d = pc_q;
          cnt_d      = cnt_sat_inc;
          // The PC stays on the halt word so resume continues right after it.
          if (!is_halt_opc) pc_d = pc_inc;
        end
        ST_HALT: begin
          // Halt word was presented once on entry; bubbles from here on.
          ir_d    = NOP_WORD;
          valid_d = 1'b0;
          if (resume_i) pc_d = pc_inc;
        end
        default: ;
      endcase
    end
  end

  assign pc_o                = pc_q;
  assign fetch_instruction_o = ir_q;
  assign fetch_valid_o       = valid_q;
  assign fetch_pc_o          = fetch_pc_q;
  assign halted_o            = (state_q == ST_HALT);
  assign fetch_count_o       = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. Three instances share clock and control
// inputs but have separate resets and memories:
//   dut_m : default parameters (fetch, stall, redirect, halt/resume)
//   dut_w : RESET_PC = 0x3FE   (PC wrap and asynchronous mid-cycle reset)
//   dut_s : CNT_BITS = 2       (counter saturation)
// Memory model: address 7 holds 0xF123 (halt opcode), every other address
// returns addr + 0x100.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_m, rst_w, rst_s;
  logic        stall, jmp, resume;
  logic [9:0]  jaddr;

  logic [9:0]  pc_m, fpc_m, pc_w, fpc_w, pc_s, fpc_s;
  logic [15:0] ins_m, ir_m, ins_w, ir_w, ins_s, ir_s;
  logic        val_m, hlt_m, val_w, hlt_w, val_s, hlt_s;
  logic [15:0] cnt_m, cnt_w;
  logic [1:0]  cnt_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [9:0] a);
    if (a == 10'd7) return 16'hF123;
    return {6'b0, a} + 16'h0100;
  endfunction

  assign ins_m = mem_word(pc_m);
  assign ins_w = mem_word(pc_w);
  assign ins_s = mem_word(pc_s);

  fetch_unit dut_m (
    .clk_i(clk), .rst_i(rst_m), .pc_o(pc_m), .instruction_i(ins_m),
    .stall_i(stall), .jmp_en_i(jmp), .jmp_addr_i(jaddr), .resume_i(resume),
    .fetch_instruction_o(ir_m), .fetch_valid_o(val_m), .fetch_pc_o(fpc_m),
    .halted_o(hlt_m), .fetch_count_o(cnt_m)
  );

  fetch_unit #(.RESET_PC(10'h3FE)) dut_w (
    .clk_i(clk), .rst_i(rst_w), .pc_o(pc_w), .instruction_i(ins_w),
    .stall_i(stall), .jmp_en_i(jmp), .jmp_addr_i(jaddr), .resume_i(resume),
    .fetch_instruction_o(ir_w), .fetch_valid_o(val_w), .fetch_pc_o(fpc_w),
    .halted_o(hlt_w), .fetch_count_o(cnt_w)
  );

  fetch_unit #(.CNT_BITS(2)) dut_s (
    .clk_i(clk), .rst_i(rst_s), .pc_o(pc_s), .instruction_i(ins_s),
    .stall_i(stall), .jmp_en_i(jmp), .jmp_addr_i(jaddr), .resume_i(resume),
    .fetch_instruction_o(ir_s), .fetch_valid_o(val_s), .fetch_pc_o(fpc_s),
    .halted_o(hlt_s), .fetch_count_o(cnt_s)
  );

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_m = 1'b0; rst_w = 1'b0; rst_s = 1'b0;
    stall = 1'b0; jmp = 1'b0; resume = 1'b0; jaddr = '0;
    #3;
    checks++;
    if (pc_m !== 10'h0 || ir_m !== 16'h0 || val_m !== 1'b0 || fpc_m !== 10'h0 ||
        hlt_m !== 1'b0 || cnt_m !== 16'h0) begin
      errors++;
      $display("FAIL reset got pc=%h ir=%h v=%b fpc=%h h=%b cnt=%0d exp pc=0 ir=0 v=0 fpc=0 h=0 cnt=0",
               pc_m, ir_m, val_m, fpc_m, hlt_m, cnt_m);
    end
    @(negedge clk);
    rst_m = 1'b1;
  endtask

  task automatic test_straight();
    checks++;
    if (pc_m !== 10'd0) begin
      errors++; $display("FAIL straight_pc0 got=%h exp=000", pc_m);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (pc_m !== 10'(i) || ir_m !== 16'h0100 + 16'(i - 1) || fpc_m !== 10'(i - 1) ||
          val_m !== 1'b1 || cnt_m !== 16'(i)) begin
        errors++;
        $display("FAIL straight_%0d got pc=%h ir=%h fpc=%h v=%b cnt=%0d exp pc=%h ir=%h fpc=%h v=1 cnt=%0d",
                 i, pc_m, ir_m, fpc_m, val_m, cnt_m, 10'(i), 16'h0100 + 16'(i - 1), 10'(i - 1), i);
      end
    end
  endtask

  task automatic test_stall();
    tick(); tick();   // PC now 5, IR holds word of 4
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pc_m !== 10'd5 || ir_m !== 16'h0104 || fpc_m !== 10'd4 || val_m !== 1'b1 ||
          cnt_m !== 16'd5) begin
        errors++;
        $display("FAIL stall_hold_%0d got pc=%h ir=%h fpc=%h v=%b cnt=%0d exp pc=005 ir=0104 fpc=004 v=1 cnt=5",
                 i, pc_m, ir_m, fpc_m, val_m, cnt_m);
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if (pc_m !== 10'd6 || ir_m !== 16'h0105 || fpc_m !== 10'd5 || cnt_m !== 16'd6) begin
      errors++;
      $display("FAIL stall_release got pc=%h ir=%h fpc=%h cnt=%0d exp pc=006 ir=0105 fpc=005 cnt=6",
               pc_m, ir_m, fpc_m, cnt_m);
    end
  endtask

  task automatic test_redirect();
    stall = 1'b1; jmp = 1'b1; jaddr = 10'h02A;
    tick();
    checks++;
    if (pc_m !== 10'h02A || val_m !== 1'b0 || ir_m !== 16'h0 || fpc_m !== 10'd5 ||
        cnt_m !== 16'd6) begin
      errors++;
      $display("FAIL redirect_flush got pc=%h v=%b ir=%h fpc=%h cnt=%0d exp pc=02a v=0 ir=0000 fpc=005 cnt=6",
               pc_m, val_m, ir_m, fpc_m, cnt_m);
    end
    stall = 1'b0; jmp = 1'b0;
    tick();
    checks++;
    if (ir_m !== 16'h012A || val_m !== 1'b1 || fpc_m !== 10'h02A || pc_m !== 10'h02B ||
        cnt_m !== 16'd7) begin
      errors++;
      $display("FAIL redirect_target got ir=%h v=%b fpc=%h pc=%h cnt=%0d exp ir=012a v=1 fpc=02a pc=02b cnt=7",
               ir_m, val_m, fpc_m, pc_m, cnt_m);
    end
  endtask

  task automatic test_halt_resume();
    jmp = 1'b1; jaddr = 10'd7;
    tick();
    jmp = 1'b0;
    // Stall while the halt word is on the bus: nothing may change.
    stall = 1'b1;
    tick();
    checks++;
    if (pc_m !== 10'd7 || hlt_m !== 1'b0 || val_m !== 1'b0 || cnt_m !== 16'd7) begin
      errors++;
      $display("FAIL halt_stalled got pc=%h h=%b v=%b cnt=%0d exp pc=007 h=0 v=0 cnt=7",
               pc_m, hlt_m, val_m, cnt_m);
    end
    stall = 1'b0;
    tick();
    checks++;
    if (ir_m !== 16'hF123 || fpc_m !== 10'd7 || hlt_m !== 1'b1 || pc_m !== 10'd7 ||
        val_m !== 1'b1 || cnt_m !== 16'd8) begin
      errors++;
      $display("FAIL halt_enter got ir=%h fpc=%h h=%b pc=%h v=%b cnt=%0d exp ir=f123 fpc=007 h=1 pc=007 v=1 cnt=8",
               ir_m, fpc_m, hlt_m, pc_m, val_m, cnt_m);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (pc_m !== 10'd7 || val_m !== 1'b0 || ir_m !== 16'h0 || hlt_m !== 1'b1 ||
          cnt_m !== 16'd8) begin
        errors++;
        $display("FAIL halt_bubble_%0d got pc=%h v=%b ir=%h h=%b cnt=%0d exp pc=007 v=0 ir=0000 h=1 cnt=8",
                 i, pc_m, val_m, ir_m, hlt_m, cnt_m);
      end
    end
    resume = 1'b1;
    tick();
    checks++;
    if (pc_m !== 10'd8 || hlt_m !== 1'b0 || val_m !== 1'b0) begin
      errors++;
      $display("FAIL resume got pc=%h h=%b v=%b exp pc=008 h=0 v=0", pc_m, hlt_m, val_m);
    end
    resume = 1'b0;
    tick();
    checks++;
    if (ir_m !== 16'h0108 || val_m !== 1'b1 || fpc_m !== 10'd8 || pc_m !== 10'd9 ||
        cnt_m !== 16'd9) begin
      errors++;
      $display("FAIL resume_fetch got ir=%h v=%b fpc=%h pc=%h cnt=%0d exp ir=0108 v=1 fpc=008 pc=009 cnt=9",
               ir_m, val_m, fpc_m, pc_m, cnt_m);
    end
  endtask

  task automatic test_wrap_reset();
    logic [9:0]  exp_pc [3];
    logic [15:0] exp_ir [3];
    exp_pc = '{10'h3FF, 10'h000, 10'h001};
    exp_ir = '{16'h04FE, 16'h04FF, 16'h0100};
    checks++;
    if (pc_w !== 10'h3FE || val_w !== 1'b0) begin
      errors++; $display("FAIL wrap_reset_pc got pc=%h v=%b exp pc=3fe v=0", pc_w, val_w);
    end
    @(negedge clk);
    rst_w = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pc_w !== exp_pc[i] || ir_w !== exp_ir[i]) begin
        errors++;
        $display("FAIL wrap_%0d got pc=%h ir=%h exp pc=%h ir=%h", i, pc_w, ir_w, exp_pc[i], exp_ir[i]);
      end
    end
    // Assert reset mid-cycle, well away from any clock edge.
    #2 rst_w = 1'b0;
    #1;
    checks++;
    if (pc_w !== 10'h3FE || ir_w !== 16'h0 || val_w !== 1'b0 || fpc_w !== 10'h0 ||
        hlt_w !== 1'b0 || cnt_w !== 16'h0) begin
      errors++;
      $display("FAIL async_reset got pc=%h ir=%h v=%b fpc=%h h=%b cnt=%0d exp pc=3fe ir=0 v=0 fpc=0 h=0 cnt=0",
               pc_w, ir_w, val_w, fpc_w, hlt_w, cnt_w);
    end
    @(negedge clk);
    rst_w = 1'b1;
    tick();
    checks++;
    if (pc_w !== 10'h3FF || ir_w !== 16'h04FE || fpc_w !== 10'h3FE || cnt_w !== 16'd1) begin
      errors++;
      $display("FAIL restart got pc=%h ir=%h fpc=%h cnt=%0d exp pc=3ff ir=04fe fpc=3fe cnt=1",
               pc_w, ir_w, fpc_w, cnt_w);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt [6];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    @(negedge clk);
    rst_s = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (cnt_s !== exp_cnt[i] || val_s !== 1'b1) begin
        errors++;
        $display("FAIL sat_%0d got cnt=%0d v=%b exp cnt=%0d v=1", i, cnt_s, val_s, exp_cnt[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_straight();
    test_stall();
    test_redirect();
    test_halt_resume();
    test_wrap_reset();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
